// File: rtl/rot_share_arb.sv
// Two-requester round-robin arbiter sharing one rotate-left/right datapath,
// with a single registered result stage and saturating per-requester grant counters.
module rot_share_arb #(
  parameter int W  = 32,
  parameter int SW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_data,
  input  logic          req0_dir,
  input  logic [SW-1:0] req0_amt,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_data,
  input  logic          req1_dir,
  input  logic [SW-1:0] req1_amt,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic          res_id,
  output logic [CW-1:0] gnt_cnt0,
  output logic [CW-1:0] gnt_cnt1
);

  logic          last_grant;
  logic          can_accept;
  logic          grant0;
  logic          grant1;
  logic          acc0;
  logic          acc1;
  logic [W-1:0]  rot_in;
  logic          rot_dir;
  logic [SW-1:0] rot_amt;
  logic [W-1:0]  rot_out;
  logic [2*W-1:0] dbl;
  logic [2*W-1:0] shl;
  logic [2*W-1:0] shr;

  // A result leaving this cycle frees the register for a new one in the same cycle.
  assign can_accept = !res_valid || res_ready;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case ({req1_valid, req0_valid})
      2'b01:   grant0 = 1'b1;
      2'b10:   grant1 = 1'b1;
      2'b11: begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end
      default: ;
    endcase
  end

  assign req0_ready = grant0 && can_accept;
  assign req1_ready = grant1 && can_accept;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;

  assign rot_in  = grant1 ? req1_data : req0_data;
  assign rot_dir = grant1 ? req1_dir  : req0_dir;
  assign rot_amt = grant1 ? req1_amt  : req0_amt;

  // Rotation as a shift of the operand concatenated with itself; the wanted window
  // is the upper half for left and the lower half for right.
  assign dbl     = {rot_in, rot_in};
  assign shl     = dbl << rot_amt;
  assign shr     = dbl >> rot_amt;
  assign rot_out = rot_dir ? shr[W-1:0] : shl[2*W-1:W];

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
      gnt_cnt0   <= '0;
      gnt_cnt1   <= '0;
    end else if (acc0 || acc1) begin
      res_valid  <= 1'b1;
      res_data   <= rot_out;
      res_id     <= acc1;
      last_grant <= acc1;
      if (acc0 && gnt_cnt0 != {CW{1'b1}}) gnt_cnt0 <= gnt_cnt0 + CW'(1);
      if (acc1 && gnt_cnt1 != {CW{1'b1}}) gnt_cnt1 <= gnt_cnt1 + CW'(1);
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rot_share_arb.sv
// Bench for rot_share_arb: directed vector table, hand-written corner sequences and
// random traffic, all checked against a bit-level behavioural model of the rules.
module tb_rot_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_dir, req1_dir, res_ready;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_amt, req1_amt;
  logic        req0_ready, req1_ready, res_valid, res_id;
  logic [31:0] res_data;
  logic [15:0] gnt_cnt0, gnt_cnt1;
  // small-counter instance shares all inputs
  logic        s_req0_ready, s_req1_ready, s_res_valid, s_res_id;
  logic [31:0] s_res_data;
  logic [3:0]  s_gnt_cnt0, s_gnt_cnt1;

  always #5 clk = ~clk;

  rot_share_arb #(.W(32), .SW(5), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_dir(req0_dir), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_dir(req1_dir), .req1_amt(req1_amt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  rot_share_arb #(.W(32), .SW(5), .CW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_data(req0_data),
    .req0_dir(req0_dir), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_data(req1_data),
    .req1_dir(req1_dir), .req1_amt(req1_amt),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data), .res_id(s_res_id),
    .gnt_cnt0(s_gnt_cnt0), .gnt_cnt1(s_gnt_cnt1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model state
  bit        m_valid;
  bit [31:0] m_data;
  bit        m_id;
  int        m_last;
  int        m_cnt0, m_cnt1, m_scnt0, m_scnt1;
  logic      g_rdy0, g_rdy1;

  function automatic bit [31:0] rot_ref(input bit [31:0] d, input bit dir, input int amt);
    bit [31:0] o;
    for (int i = 0; i < 32; i++)
      o[i] = dir ? d[(i + amt) % 32] : d[(i - amt + 32) % 32];
    return o;
  endfunction

  // One clock: drive inputs, check readies, clock, update model, check registers.
  task automatic step(input bit rn, input bit v0, input bit [31:0] d0, input bit dir0,
                      input bit [4:0] a0, input bit v1, input bit [31:0] d1,
                      input bit dir1, input bit [4:0] a1, input bit rr);
    bit can, e0, e1;
    rst_n = rn; req0_valid = v0; req0_data = d0; req0_dir = dir0; req0_amt = a0;
    req1_valid = v1; req1_data = d1; req1_dir = dir1; req1_amt = a1; res_ready = rr;
    can = !m_valid || rr;
    e0  = v0 && (!v1 || m_last == 1) && can;
    e1  = v1 && (!v0 || m_last == 0) && can;
    #1;
    g_rdy0 = req0_ready;
    g_rdy1 = req1_ready;
    check("req0_ready", 64'(req0_ready), 64'(e0));
    check("req1_ready", 64'(req1_ready), 64'(e1));
    check("sat_req0_ready", 64'(s_req0_ready), 64'(e0));
    @(posedge clk);
    if (!rn) begin
      m_valid = 0; m_data = 0; m_id = 0; m_last = 1;
      m_cnt0 = 0; m_cnt1 = 0; m_scnt0 = 0; m_scnt1 = 0;
    end else if (e0 || e1) begin
      m_valid = 1;
      m_data  = e0 ? rot_ref(d0, dir0, int'(a0)) : rot_ref(d1, dir1, int'(a1));
      m_id    = e1;
      m_last  = e1 ? 1 : 0;
      if (e0) begin m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : m_cnt0; m_scnt0 = (m_scnt0 < 15) ? m_scnt0 + 1 : m_scnt0; end
      if (e1) begin m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : m_cnt1; m_scnt1 = (m_scnt1 < 15) ? m_scnt1 + 1 : m_scnt1; end
    end else if (m_valid && rr) begin
      m_valid = 0;
    end
    @(negedge clk);
    check("res_valid", 64'(res_valid), 64'(m_valid));
    check("res_data",  64'(res_data),  64'(m_data));
    check("res_id",    64'(res_id),    64'(m_id));
    check("gnt_cnt0",  64'(gnt_cnt0),  64'(m_cnt0));
    check("gnt_cnt1",  64'(gnt_cnt1),  64'(m_cnt1));
    check("sat_gnt_cnt0", 64'(s_gnt_cnt0), 64'(m_scnt0));
    check("sat_gnt_cnt1", 64'(s_gnt_cnt1), 64'(m_scnt1));
  endtask

  typedef struct {
    logic v0; logic [31:0] d0; logic dir0; logic [4:0] a0;
    logic v1; logic [31:0] d1; logic dir1; logic [4:0] a1;
    logic rr;
    logic e_rdy0; logic e_rdy1; logic e_valid; logic [31:0] e_data; logic e_id;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit [31:0] held;
    bit p0, p1, pdir0, pdir1, rv0, rv1;
    bit [31:0] pd0, pd1;
    bit [4:0] pa0, pa1;

    vecs[0] = '{1'b1, 32'h8000_0001, 1'b0, 5'd1,  1'b0, 32'h0, 1'b0, 5'd0,  1'b1,
                1'b1, 1'b0, 1'b1, 32'h0000_0003, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 1'b0, 5'd0,  1'b1, 32'h0000_0001, 1'b1, 5'd4,  1'b1,
                1'b0, 1'b1, 1'b1, 32'h1000_0000, 1'b1};
    vecs[2] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 5'd0,  1'b0, 32'h0, 1'b0, 5'd0,  1'b1,
                1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 5'd0,  1'b1, 32'hDEAD_BEEF, 1'b0, 5'd0,  1'b1,
                1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_000F, 1'b1, 5'd31,  1'b0, 32'h0, 1'b0, 5'd0,  1'b1,
                1'b1, 1'b0, 1'b1, 32'h0000_001E, 1'b0};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 5'd0,  1'b0, 32'h0, 1'b0, 5'd0,  1'b0,
                1'b0, 1'b0, 1'b1, 32'h0000_001E, 1'b0};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 5'd0,  1'b0, 32'h0, 1'b0, 5'd0,  1'b1,
                1'b0, 1'b0, 1'b0, 32'h0000_001E, 1'b0};
    // contention after a requester-0 grant goes to requester 1
    vecs[7] = '{1'b1, 32'h0000_0001, 1'b0, 5'd0,  1'b1, 32'h1234_5678, 1'b0, 5'd8,  1'b1,
                1'b0, 1'b1, 1'b1, 32'h3456_7812, 1'b1};

    m_valid = 0; m_data = 0; m_id = 0; m_last = 1;
    m_cnt0 = 0; m_cnt1 = 0; m_scnt0 = 0; m_scnt1 = 0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("reset_res_valid", 64'(res_valid), 64'h0);
    check("reset_res_data",  64'(res_data),  64'h0);
    check("reset_gnt_cnt0",  64'(gnt_cnt0),  64'h0);

    // Directed vectors
    foreach (vecs[i]) begin
      step(1, vecs[i].v0, vecs[i].d0, vecs[i].dir0, vecs[i].a0,
           vecs[i].v1, vecs[i].d1, vecs[i].dir1, vecs[i].a1, vecs[i].rr);
      check($sformatf("vec%0d_rdy0", i), 64'(g_rdy0), 64'(vecs[i].e_rdy0));
      check($sformatf("vec%0d_rdy1", i), 64'(g_rdy1), 64'(vecs[i].e_rdy1));
      check($sformatf("vec%0d_valid", i), 64'(res_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d_data", i), 64'(res_data), 64'(vecs[i].e_data));
      check($sformatf("vec%0d_id", i), 64'(res_id), 64'(vecs[i].e_id));
    end
    check("vec_cnt0", 64'(gnt_cnt0), 64'd3);
    check("vec_cnt1", 64'(gnt_cnt1), 64'd3);

    // Contention: alternating grants starting with requester 0
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 32'hA5A5_0000 + 32'(i), 0, 5'(i), 1, 32'h5A5A_0000 + 32'(i), 1, 5'(i), 1);
      check("cont_rdy0", 64'(g_rdy0), 64'(i % 2 == 0));
      check("cont_rdy1", 64'(g_rdy1), 64'(i % 2 == 1));
      check("cont_res_id", 64'(res_id), 64'(i % 2));
    end
    check("cont_cnt0", 64'(gnt_cnt0), 64'd3);
    check("cont_cnt1", 64'(gnt_cnt1), 64'd3);

    // Backpressure: pending result stalls both requesters and stays stable
    held = res_data;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 32'h1111_1111, 0, 5'd3, 1, 32'h2222_2222, 1, 5'd5, 0);
      check("bp_rdy0", 64'(g_rdy0), 64'h0);
      check("bp_rdy1", 64'(g_rdy1), 64'h0);
      check("bp_hold", 64'(res_data), 64'(held));
      check("bp_valid", 64'(res_valid), 64'h1);
    end
    step(1, 1, 32'h1111_1111, 0, 5'd3, 1, 32'h2222_2222, 1, 5'd5, 1);
    check("bp_refill_rdy0", 64'(g_rdy0), 64'h1);
    check("bp_refill_valid", 64'(res_valid), 64'h1);
    check("bp_refill_data", 64'(res_data), 64'h8888_8888);
    check("bp_refill_id", 64'(res_id), 64'h0);

    // Reset with a stalled result pending
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("midrst_valid", 64'(res_valid), 64'h0);
    check("midrst_data", 64'(res_data), 64'h0);
    check("midrst_cnt", 64'({gnt_cnt0, gnt_cnt1}), 64'h0);
    step(1, 1, 32'hCAFE_F00D, 0, 5'd0, 1, 32'h0BAD_0BAD, 0, 5'd0, 1);
    check("midrst_first_grant", 64'(g_rdy0), 64'h1);
    check("midrst_first_id", 64'(res_id), 64'h0);

    // Counter saturation on the CW=4 instance
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 1, $urandom, 0, 5'd1, 0, 0, 0, 0, 1);
    check("sat_cnt0_stop", 64'(s_gnt_cnt0), 64'd15);
    check("sat_cnt1_zero", 64'(s_gnt_cnt1), 64'd0);
    check("wide_cnt0", 64'(gnt_cnt0), 64'd20);

    // Random traffic; a requester not accepted keeps its request stable
    p0 = 0; p1 = 0; pd0 = 0; pd1 = 0; pdir0 = 0; pdir1 = 0; pa0 = 0; pa1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0) begin
        p0 = ($urandom_range(9) < 7); pd0 = $urandom; pdir0 = 1'($urandom); pa0 = 5'($urandom);
      end
      if (!p1) begin
        p1 = ($urandom_range(9) < 7); pd1 = $urandom; pdir1 = 1'($urandom); pa1 = 5'($urandom);
      end
      rv0 = p0; rv1 = p1;
      step(($urandom_range(99) != 0), rv0, pd0, pdir0, pa0, rv1, pd1, pdir1, pa1,
           ($urandom_range(3) != 0));
      if (g_rdy0) p0 = 0;
      if (g_rdy1) p1 = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
